// File: rtl/fx_pkg.sv
// Constants and types shared by the fixed-point sqrt/square units and their benches.
package fx_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_FBITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fx_state_e;

endpackage

// File: rtl/fx_square.sv
// Iterative square: sq = (root^2 + rem) >> FBITS, one shift-add per cycle; optional FX_SQUARE_SAT_EN saturates sq on ovf.
// Latency WIDTH+1 cycles from accepted start to the one-cycle valid pulse.
// No backpressure: start is only accepted in IDLE/DONE and ignored while busy.
module fx_square
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int FBITS = FX_FBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] root,
    input  logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] sq,
    output logic             ovf
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH);

    fx_state_e        state_q, state_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sq_q, sq_d;
    logic             ovf_q, ovf_d;

    logic [AW-1:0]    acc_step;
    logic             ovf_step;
    logic             last_iter;

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign ovf_step  = |acc_step[AW-1:WIDTH+FBITS];
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sq_d     = sq_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = CALC;
                    mcand_d  = AW'(root);
                    mplier_d = root;
                    acc_d    = AW'(rem);
                    cnt_d    = '0;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Results latch only here, so they hold through any later CALC.
                if (last_iter) begin
                    state_d = DONE;
                    ovf_d   = ovf_step;
`ifdef FX_SQUARE_SAT_EN
                    sq_d    = ovf_step ? '1 : acc_step[WIDTH+FBITS-1:FBITS];
`else
                    sq_d    = acc_step[WIDTH+FBITS-1:FBITS];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sq_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sq_q     <= sq_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy  = (state_q == CALC);
    assign valid = (state_q == DONE);
    assign sq    = sq_q;
    assign ovf   = ovf_q;

endmodule
